// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/branch controller: merges per-stage stall requests, sequences branch redirects across PC stalls,
// counts PC-stall cycles. Optional stall watchdog is enabled by defining PIPE_STALL_CTRL_WDOG_EN.
module pipe_stall_ctrl #(
    parameter int WDOG_LIMIT = 1024,
    parameter int CNT_W      = 32,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_if,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic              br_req,
    input  logic [ADDR_W-1:0] br_target,
    output logic [5:0]        stall,
    output logic              br,
    output logic              pc_redirect,
    output logic [ADDR_W-1:0] pc_target,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic              wdog_err
);

    if (WDOG_LIMIT < 1) begin : g_bad_wdog_limit
        $error("pipe_stall_ctrl: WDOG_LIMIT must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pipe_stall_ctrl: CNT_W must be at least 1");
    end

    typedef enum logic {
        RUN     = 1'b0,
        BR_PEND = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pend_target, pend_target_nxt;
    logic [5:0]        stall_req;
    logic              acc;

    // Deepest requester wins; a held stage also holds everything upstream of it.
    // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        stall_req = 6'b000000;
        if (stallreq_mem) begin
            stall_req = 6'b011111;
        end else if (stallreq_ex) begin
            stall_req = 6'b001111;
        end else if (stallreq_id) begin
            stall_req = 6'b000111;
        end else if (stallreq_if) begin
            stall_req = 6'b000011;
        end
    end

    assign stall = rst ? 6'b000000 : stall_req;

    // A branch resolved while EX is frozen is stale and must not be taken.
    assign acc = br_req & ~stall[3];

    always_comb begin
        state_nxt       = state;
        pend_target_nxt = pend_target;
        br              = 1'b0;
        pc_redirect     = 1'b0;
        pc_target       = '0;

        unique case (state)
            RUN: begin
                if (acc) begin
                    br = 1'b1;
                    if (!stall[0]) begin
                        pc_redirect = 1'b1;
                        pc_target   = br_target;
                    end else begin
                        pend_target_nxt = br_target;
                        state_nxt       = BR_PEND;
                    end
                end
            end
            BR_PEND: begin
                br = 1'b1;
                if (acc) begin
                    pend_target_nxt = br_target;
                end
                // A branch accepted in the release cycle bypasses the stored target.
                if (!stall[0]) begin
                    pc_redirect = 1'b1;
                    pc_target   = acc ? br_target : pend_target;
                    state_nxt   = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        if (rst) begin
            br          = 1'b0;
            pc_redirect = 1'b0;
            pc_target   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pend_target <= '0;
        end else begin
            state       <= state_nxt;
            pend_target <= pend_target_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall[0] && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

`ifdef PIPE_STALL_CTRL_WDOG_EN
    localparam int               WD_W   = $clog2(WDOG_LIMIT + 1);
    localparam logic [WD_W-1:0]  WD_MAX = WD_W'(WDOG_LIMIT);

    logic [WD_W-1:0] wdog_cnt;

    // Counts consecutive PC-stall cycles only; any free cycle restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt <= '0;
            wdog_err <= 1'b0;
        end else if (!stall[0]) begin
            wdog_cnt <= '0;
        end else if (wdog_cnt != WD_MAX) begin
            wdog_cnt <= wdog_cnt + WD_W'(1);
            if ((wdog_cnt + WD_W'(1)) == WD_MAX) begin
                wdog_err <= 1'b1;
            end
        end
    end
`else
    assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_pipe_stall_ctrl;

    localparam int WDOG_LIMIT = 8;
    localparam int CNT_W      = 8;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;
`ifdef PIPE_STALL_CTRL_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
    logic        br_req = 1'b0;
    logic [31:0] br_target = '0;
    logic [5:0]  stall;
    logic        br, pc_redirect, wdog_err;
    logic [31:0] pc_target;
    logic [CNT_W-1:0] stall_cycles;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    pipe_stall_ctrl #(.WDOG_LIMIT(WDOG_LIMIT), .CNT_W(CNT_W), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .br_req(br_req), .br_target(br_target),
        .stall(stall), .br(br), .pc_redirect(pc_redirect), .pc_target(pc_target),
        .stall_cycles(stall_cycles), .wdog_err(wdog_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Number of pipeline stages held, counted from PC upward.
    function automatic int held_stages();
        if (stallreq_mem) return 5;
        if (stallreq_ex)  return 4;
        if (stallreq_id)  return 3;
        if (stallreq_if)  return 2;
        return 0;
    endfunction

    bit          m_pend = 0;
    logic [31:0] m_pend_tgt = '0;
    int          m_cycles = 0;
    int          m_wd_run = 0;
    bit          m_wd_err = 0;

    function automatic bit accepted();
        return !rst && br_req && (held_stages() < 4);
    endfunction

    function automatic bit pc_held();
        return !rst && (held_stages() > 0);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            int          n;
            bit          busy;
            logic [31:0] e_stall, e_tgt;
            bit          e_redir;
            n       = held_stages();
            e_stall = rst ? 32'd0 : ((32'd1 << n) - 32'd1);
            busy    = !rst && (m_pend || accepted());
            e_redir = busy && !pc_held();
            e_tgt   = !e_redir ? 32'd0 : (accepted() ? br_target : m_pend_tgt);
            check("stall", 32'(stall), e_stall);
            check("br", 32'(br), 32'(busy));
            check("pc_redirect", 32'(pc_redirect), 32'(e_redir));
            check("pc_target", pc_target, e_tgt);
            check("stall_cycles", 32'(stall_cycles), 32'(m_cycles));
            check("wdog_err", 32'(wdog_err), 32'(m_wd_err & WDOG_ON));
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m_pend = 0; m_pend_tgt = '0; m_cycles = 0; m_wd_run = 0; m_wd_err = 0;
        end else begin
            if ((m_pend || accepted()) && pc_held()) begin
                m_pend = 1;
                if (accepted()) m_pend_tgt = br_target;
            end else if (!pc_held()) begin
                m_pend = 0;
            end
            if (pc_held()) begin
                if (m_cycles < CNT_MAX) m_cycles++;
                if (m_wd_run < WDOG_LIMIT) m_wd_run++;
                if (m_wd_run == WDOG_LIMIT) m_wd_err = 1;
            end else begin
                m_wd_run = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit i, input bit d, input bit e, input bit m, input bit b, input logic [31:0] t);
        stallreq_if = i; stallreq_id = d; stallreq_ex = e; stallreq_mem = m;
        br_req = b; br_target = t;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 32'h0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset forces outputs low even with requests active.
        drive(1, 0, 0, 1, 1, 32'hDEAD_BEEF);
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_br", 32'(br), 32'h0);
        check("rst_redirect", 32'(pc_redirect), 32'h0);
        tick();
        chk_en = 1'b1;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        check("post_rst_cycles", 32'(stall_cycles), 32'h0);
        check("post_rst_wdog", 32'(wdog_err), 32'h0);
        tick();

        // Priority encoding.
        drive(1, 0, 0, 1, 0, 32'h0); @(negedge clk); check("prio_if_mem", 32'(stall), 32'h1F); tick();
        drive(0, 1, 0, 0, 0, 32'h0); @(negedge clk); check("prio_id", 32'(stall), 32'h07); tick();
        drive(0, 0, 0, 0, 0, 32'h0); @(negedge clk); check("prio_none", 32'(stall), 32'h00); tick();

        // Unstalled branch.
        drive(0, 0, 0, 0, 1, 32'h100);
        @(negedge clk);
        check("ub_br", 32'(br), 32'h1);
        check("ub_redir", 32'(pc_redirect), 32'h1);
        check("ub_tgt", pc_target, 32'h100);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        @(negedge clk); check("ub_br_next", 32'(br), 32'h0); tick();

        // Pending branch across 3 further fetch-stall cycles.
        drive(1, 0, 0, 0, 1, 32'h200);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("pend_br", 32'(br), 32'h1);
            check("pend_noredir", 32'(pc_redirect), 32'h0);
            tick();
            drive(1, 0, 0, 0, 0, 32'h0);
        end
        drive(0, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        check("pend_redir", 32'(pc_redirect), 32'h1);
        check("pend_tgt", pc_target, 32'h200);
        tick();
        @(negedge clk); check("pend_once", 32'(pc_redirect), 32'h0); tick();

        // Overwrite while pending: latest target wins.
        drive(1, 0, 0, 0, 1, 32'h200); tick();
        drive(1, 0, 0, 0, 1, 32'h300); tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        check("ovw_redir", 32'(pc_redirect), 32'h1);
        check("ovw_tgt", pc_target, 32'h300);
        tick();

        // Branch during EX stall is ignored.
        drive(0, 0, 1, 0, 1, 32'h400);
        @(negedge clk);
        check("guard_br", 32'(br), 32'h0);
        check("guard_redir", 32'(pc_redirect), 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        @(negedge clk); check("guard_after", 32'(br), 32'h0); tick();

        // Reset while pending drops the redirect.
        drive(1, 0, 0, 0, 1, 32'h500); tick();
        rst = 1'b1; drive(1, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        check("rstp_stall", 32'(stall), 32'h0);
        check("rstp_br", 32'(br), 32'h0);
        check("rstp_redir", 32'(pc_redirect), 32'h0);
        tick();
        rst = 1'b0; drive(0, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        check("rstp_cycles", 32'(stall_cycles), 32'h0);
        check("rstp_noredir", 32'(pc_redirect), 32'h0);
        check("rstp_nobr", 32'(br), 32'h0);
        tick();

        // Watchdog: two 7-cycle stalls do not trip, an 8-cycle one does.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            drive(0, 0, 0, 1, 0, 32'h0);
            repeat (7) tick();
            drive(0, 0, 0, 0, 0, 32'h0);
            tick();
        end
        @(negedge clk);
        check("wd7_err", 32'(wdog_err), 32'h0);
        check("wd7_cycles", 32'(stall_cycles), 32'd14);
        drive(0, 0, 0, 1, 0, 32'h0);
        repeat (8) tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        @(negedge clk); check("wd8_err", 32'(wdog_err), 32'(WDOG_ON)); tick();
        @(negedge clk); check("wd8_sticky", 32'(wdog_err), 32'(WDOG_ON));
        check("wd8_cycles", 32'(stall_cycles), 32'd22);
        tick();

        // Counter saturation.
        do_reset();
        drive(1, 0, 0, 0, 0, 32'h0);
        repeat (CNT_MAX + 5) tick();
        @(negedge clk); check("cnt_sat", 32'(stall_cycles), 32'(CNT_MAX)); tick();

        // Randomized traffic, stall requests weighted toward short bursts.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 2) == 0, $urandom);
            tick();
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
